abc_stimulus_seq: RTL

//  Upstream driver for the 3-input logic-function stage (inputs A,B,C; outputs S1..S6).

---
 rtl/abc_stim_pkg.sv | 16 +
 rtl/abc_stimulus_seq_debounce.sv | 51 +++++
 rtl/abc_stimulus_seq.sv | 106 ++++++++++
 3 files changed

// File: rtl/abc_stim_pkg.sv
// Shared types and helpers for the abc stimulus sequencer.
// Holds the mode FSM encoding and the Gray-code mapping.
package abc_stim_pkg;

    localparam int ABC_W = 3;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } stim_state_t;

    function automatic logic [ABC_W-1:0] to_gray(input logic [ABC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/abc_stimulus_seq_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, debouncer, rising-edge press pulse.
// A button already held when reset releases must be seen released before it can press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          settled;

    assign settled = (sync1 == sync2) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            armed  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync1 != sync2) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (settled) begin
                stable <= sync2;
            end
            // Only a debounced low after reset proves the button was released.
            if (settled && !sync2) begin
                armed <= 1'b1;
            end
            press <= settled && sync2 && !stable && armed;
        end
    end

endmodule

// File: rtl/abc_stimulus_seq.sv
// Steps the 3-bit {A,B,C} vector through all 8 rows, manually or on a dwell timer.
// Define STIM_GRAY_EN to emit the rows in Gray order instead of binary order.
module abc_stimulus_seq
    import abc_stim_pkg::*;
#(
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             btn_mode,
    output logic [ABC_W-1:0] abc,
    output logic             vec_valid,
    output logic             wrap,
    output logic             auto_mode
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);

    stim_state_t      state;
    logic [DW-1:0]    dwell;
    logic [ABC_W-1:0] idx;
    logic [ABC_W-1:0] idx_nxt;
    logic [ABC_W-1:0] code_nxt;
    logic             step_press;
    logic             mode_press;
    logic             dwell_done;
    logic             advance;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .stable(),
        .press (step_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_mode),
        .stable(),
        .press (mode_press)
    );

    assign idx_nxt = idx + ABC_W'(1);

`ifdef STIM_GRAY_EN
    assign code_nxt = to_gray(idx_nxt);
`else
    assign code_nxt = idx_nxt;
`endif

    // A mode press wins over both a step press and a dwell expiry.
    assign dwell_done = (state == AUTO) && (dwell == DWELL_MAX);
    assign advance    = !mode_press &&
                        (((state == MANUAL) && step_press) || dwell_done);
    assign auto_mode  = (state == AUTO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MANUAL;
            dwell     <= '0;
            idx       <= '0;
            abc       <= '0;
            vec_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            vec_valid <= advance;
            wrap      <= advance && (&idx);
            if (advance) begin
                idx <= idx_nxt;
                abc <= code_nxt;
            end
            unique case (state)
                MANUAL: begin
                    if (mode_press) begin
                        state <= AUTO;
                        dwell <= '0;
                    end
                end
                AUTO: begin
                    if (mode_press) begin
                        state <= MANUAL;
                        dwell <= '0;
                    end else if (dwell_done) begin
                        dwell <= '0;
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
                default: begin
                    state <= MANUAL;
                    dwell <= '0;
                end
            endcase
        end
    end

endmodule
